// File: rtl/nms_column_feeder_pkg.sv
// Shared constants and types for the NMS column feeder.
package nms_column_feeder_pkg;

  // Default frame geometry and magnitude width
  localparam int IMG_WIDTH_DEF  = 960;
  localparam int IMG_HEIGHT_DEF = 720;
  localparam int BIT_LENGTH_DEF = 5;

  // Quantised gradient direction carried alongside each pixel
  typedef enum logic [1:0] {
    ANG_0   = 2'd0,
    ANG_45  = 2'd1,
    ANG_90  = 2'd2,
    ANG_135 = 2'd3
  } angle_t;

  // Frame sequencing states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_STREAM = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

endpackage

// File: rtl/nms_line_buffer.sv
// Circular single-line buffer: combinational read of the old entry at addr,
// write of the new entry at the same addr on the clock edge.
module nms_line_buffer #(
  parameter int DEPTH = 960,
  parameter int WIDTH = 5,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Old contents are visible until the edge, so read-before-write falls out naturally
  assign rd_data = r_mem[addr];

  // Storage needs no reset: FILL rewrites every entry before it is read out
  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wr_data;
  end

endmodule

// File: rtl/nms_column_feeder.sv
// Buffers two raster lines and emits one 3-pixel vertical column per cycle,
// plus the centre-row angle one column late, framed for the NMS stage.
module nms_column_feeder
  import nms_column_feeder_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int BIT_LENGTH = BIT_LENGTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [BIT_LENGTH-1:0] pixel_in,
  input  logic [1:0]            angle_in,
  output logic [BIT_LENGTH-1:0] col_pix0,
  output logic [BIT_LENGTH-1:0] col_pix1,
  output logic [BIT_LENGTH-1:0] col_pix2,
  output logic [1:0]            angle_out,
  output logic                  enable,
  output logic                  frame_done,
  output logic                  error
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  state_t                r_state, w_state_nxt;
  logic [XW-1:0]         r_x;
  logic [YW-1:0]         r_y;
  logic                  r_started;
  logic                  r_flush_col;
  angle_t                r_ang_hold;

  logic                  w_active, w_accept, w_gap, w_arm;
  logic                  w_last_x, w_last_y, w_fill_end;
  logic [BIT_LENGTH-1:0] w_row_a, w_row_b;
  logic [1:0]            w_ang_a;

  assign w_active   = (r_state == ST_FILL) || (r_state == ST_STREAM);
  assign w_accept   = w_active && in_valid;
  // Waiting in FILL is allowed only until the first pixel arrives
  assign w_gap      = !in_valid &&
                      ((r_state == ST_STREAM) || (r_state == ST_FILL && r_started));
  assign w_arm      = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last_x   = (r_x == XW'(IMG_WIDTH - 1));
  assign w_last_y   = (r_y == YW'(IMG_HEIGHT - 1));
  assign w_fill_end = w_last_x && (r_y == YW'(1));

  // lineA holds row y-1, lineB row y-2; lineA's old entry shifts down into lineB
  nms_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(BIT_LENGTH)) u_line_a (
    .clk(clk), .we(w_accept), .addr(r_x), .wr_data(pixel_in), .rd_data(w_row_a)
  );

  nms_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(BIT_LENGTH)) u_line_b (
    .clk(clk), .we(w_accept), .addr(r_x), .wr_data(w_row_a), .rd_data(w_row_b)
  );

  // Only the centre row's angle is ever needed
  nms_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(2)) u_line_ang (
    .clk(clk), .we(w_accept), .addr(r_x), .wr_data(angle_in), .rd_data(w_ang_a)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_FILL;
      ST_FILL: begin
        if (w_gap)                       w_state_nxt = ST_ERROR;
        else if (w_accept && w_fill_end) w_state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (w_gap)                                 w_state_nxt = ST_ERROR;
        else if (w_accept && w_last_x && w_last_y) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH:  w_state_nxt = ST_DONE;
      ST_DONE:   if (start) w_state_nxt = ST_FILL;
      ST_ERROR:  w_state_nxt = ST_ERROR;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Raster position; held at the last pixel until the next frame is armed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x       <= '0;
      r_y       <= '0;
      r_started <= 1'b0;
    end else if (w_arm) begin
      r_x       <= '0;
      r_y       <= '0;
      r_started <= 1'b0;
    end else if (w_accept) begin
      r_started <= 1'b1;
      if (!w_last_x)      r_x <= r_x + XW'(1);
      else if (!w_last_y) begin
        r_x <= '0;
        r_y <= r_y + YW'(1);
      end
    end
  end

  // Column outputs, angle delay slot, framing and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_pix0    <= '0;
      col_pix1    <= '0;
      col_pix2    <= '0;
      angle_out   <= '0;
      enable      <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
      r_flush_col <= 1'b0;
      r_ang_hold  <= ANG_0;
    end else begin
      enable      <= 1'b0;
      r_flush_col <= (r_state == ST_FLUSH);
      frame_done  <= r_flush_col;
      error       <= error | w_gap;
      // Runs during FILL too so the first STREAM column sees the row-0 tail angle
      if (w_accept) r_ang_hold <= angle_t'(w_ang_a);
      if (r_state == ST_STREAM && in_valid) begin
        col_pix0  <= w_row_b;
        col_pix1  <= w_row_a;
        col_pix2  <= pixel_in;
        angle_out <= r_ang_hold;
        enable    <= 1'b1;
      end else if (r_state == ST_FLUSH) begin
        // Zero column that walks the NMS centre onto the last pixel
        col_pix0  <= '0;
        col_pix1  <= '0;
        col_pix2  <= '0;
        angle_out <= r_ang_hold;
        enable    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nms_column_feeder.sv
// Directed bench for nms_column_feeder on a 4x4 frame.
module tb_nms_column_feeder;

  localparam int W = 4;
  localparam int H = 4;
  localparam int BL = 5;

  logic clk = 1'b0;
  logic reset, start, in_valid;
  logic [BL-1:0] pixel_in, col_pix0, col_pix1, col_pix2;
  logic [1:0] angle_in, angle_out;
  logic enable, frame_done, error;

  nms_column_feeder #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .BIT_LENGTH(BL)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .pixel_in(pixel_in), .angle_in(angle_in),
    .col_pix0(col_pix0), .col_pix1(col_pix1), .col_pix2(col_pix2),
    .angle_out(angle_out), .enable(enable), .frame_done(frame_done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct { int c0; int c1; int c2; int ang; } col_t;

  col_t q[$];
  col_t exp_tab[2][9];
  int   fd_cnt, cyc, first_cyc, last_cyc;
  int   tests, fails;

  // Monitor: collect every enabled column, count frame_done pulses
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!reset) begin
      if (enable) begin
        if (q.size() == 0) first_cyc = cyc;
        last_cyc = cyc;
        q.push_back('{int'(col_pix0), int'(col_pix1), int'(col_pix2), int'(angle_out)});
      end
      if (frame_done) fd_cnt = fd_cnt + 1;
    end
  end

  function automatic col_t mk(int a, int b, int c, int d);
    col_t r;
    r.c0 = a; r.c1 = b; r.c2 = c; r.ang = d;
    return r;
  endfunction

  function automatic int pk(col_t c);
    return (c.c0 << 24) | (c.c1 << 16) | (c.c2 << 8) | c.ang;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Assumes caller sits just after a posedge
  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // mode 0: pix=4y+x, ang=x ; mode 1: pix=16+4y+x, ang=3-x
  task automatic feed(input int mode, input int n, input int gap_idx, input int start_idx);
    for (int i = 0; i < n; i++) begin
      if (i == gap_idx) begin
        in_valid = 1'b0;
        tick(1);
      end
      in_valid = 1'b1;
      start    = (i == start_idx);
      pixel_in = BL'((mode == 1 ? 16 : 0) + i);
      angle_in = 2'((mode == 1) ? 3 - (i % W) : (i % W));
      tick(1);
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic check_frame(input string name, input int k);
    check({name, ".count"}, q.size(), 9);
    check({name, ".contig"}, last_cyc - first_cyc + 1, 9);
    for (int i = 0; i < 9; i++) begin
      if (i < q.size()) check($sformatf("%s.col%0d", name, i), pk(q[i]), pk(exp_tab[k][i]));
      else              check($sformatf("%s.col%0d", name, i), -1, pk(exp_tab[k][i]));
    end
  endtask

  initial begin
    tests = 0; fails = 0; fd_cnt = 0; cyc = 0; first_cyc = 0; last_cyc = 0;
    exp_tab[0][0] = mk(0, 4, 8, 3);    exp_tab[0][1] = mk(1, 5, 9, 0);
    exp_tab[0][2] = mk(2, 6, 10, 1);   exp_tab[0][3] = mk(3, 7, 11, 2);
    exp_tab[0][4] = mk(4, 8, 12, 3);   exp_tab[0][5] = mk(5, 9, 13, 0);
    exp_tab[0][6] = mk(6, 10, 14, 1);  exp_tab[0][7] = mk(7, 11, 15, 2);
    exp_tab[0][8] = mk(0, 0, 0, 3);
    exp_tab[1][0] = mk(16, 20, 24, 0); exp_tab[1][1] = mk(17, 21, 25, 3);
    exp_tab[1][2] = mk(18, 22, 26, 2); exp_tab[1][3] = mk(19, 23, 27, 1);
    exp_tab[1][4] = mk(20, 24, 28, 0); exp_tab[1][5] = mk(21, 25, 29, 3);
    exp_tab[1][6] = mk(22, 26, 30, 2); exp_tab[1][7] = mk(23, 27, 31, 1);
    exp_tab[1][8] = mk(0, 0, 0, 0);

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; pixel_in = '0; angle_in = '0;
    tick(3);
    check("reset.outs", int'({col_pix0, col_pix1, col_pix2, angle_out, enable, frame_done, error}), 0);
    reset = 1'b0;

    // Junk while IDLE must be ignored
    in_valid = 1'b1; pixel_in = 5'd31; angle_in = 2'd2;
    tick(3);
    in_valid = 1'b0;
    check("idle.no_enable", q.size(), 0);

    // Frame 1: pix=4y+x, ang=x
    pulse_start();
    feed(0, W * H, -1, -1);
    tick(6);
    check_frame("f1", 0);
    check("f1.frame_done", fd_cnt, 1);
    check("f1.error", int'(error), 0);

    // Frame 2 after frame_done, with junk in DONE and a stray start mid-stream
    q.delete();
    in_valid = 1'b1; pixel_in = 5'd9; tick(2); in_valid = 1'b0;
    check("done.no_enable", q.size(), 0);
    pulse_start();
    feed(1, W * H, -1, 10);
    tick(6);
    check_frame("f2", 1);
    check("f2.frame_done", fd_cnt, 2);

    // Reset in the middle of STREAM
    q.delete();
    pulse_start();
    feed(0, 10, -1, -1);
    check("rst.pre_enable", int'(enable), 1);
    reset = 1'b1;
    #1;
    check("rst.async_outs", int'({col_pix0, col_pix1, col_pix2, angle_out, enable, frame_done, error}), 0);
    tick(1);
    reset = 1'b0;
    q.delete();
    fd_cnt = 0;
    pulse_start();
    feed(0, W * H, -1, -1);
    tick(6);
    check_frame("rst.f", 0);
    check("rst.frame_done", fd_cnt, 1);

    // Gap at pixel (2,1): one column then ERROR, sticky
    q.delete();
    fd_cnt = 0;
    pulse_start();
    feed(0, W * H, 9, -1);
    tick(6);
    check("gap.count", q.size(), 1);
    if (q.size() > 0) check("gap.col0", pk(q[0]), pk(exp_tab[0][0]));
    check("gap.error", int'(error), 1);
    check("gap.enable", int'(enable), 0);
    check("gap.no_done", fd_cnt, 0);
    pulse_start();
    in_valid = 1'b1; tick(4); in_valid = 1'b0;
    check("gap.sticky", int'(error), 1);
    check("gap.still_none", q.size(), 1);
    reset = 1'b1; tick(1); reset = 1'b0; tick(1);
    check("gap.reset_clears", int'(error), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard bound on simulated time
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
